// File: rtl/uart_tx_framer.sv
// uart_tx_framer: packetizer in front of a byte-wide UART transmitter.
// Captures one result word plus a flag byte and emits the packet
//   SYNC_BYTE, flags, data bytes MSB-first, XOR checksum (flags ^ data bytes)
// one byte at a time through the transmitter's tx_start/tx_busy handshake.
module uart_tx_framer #(
    parameter int          DATA_BYTES = 2,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    input  logic [8*DATA_BYTES-1:0]   res_data_i,
    input  logic [7:0]                res_flags_i,
    output logic [7:0]                tx_data_o,
    output logic                      tx_start_o,
    input  logic                      tx_busy_i,
    output logic                      busy_o,
    output logic                      pkt_done_o
);

    localparam int PKT_LEN = DATA_BYTES + 3;
    localparam int IDX_W   = $clog2(PKT_LEN);

    localparam logic [IDX_W-1:0] IDX_SYNC  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_FLAGS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PKT_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [8*DATA_BYTES-1:0]   data_q;
    logic [7:0]                flags_q;
    logic [7:0]                csum_q;
    logic [7:0]                tx_data_q;
    logic                      tx_start_q;
    logic                      pkt_done_q;
    logic                      ready_q;

    logic [7:0]                csum_d;
    logic [7:0]                data_byte_s;
    logic [7:0]                byte_d;

    // XOR of the flag byte and every result byte; the sync byte is not covered.
    function automatic logic [7:0] xor_checksum(
        input logic [7:0]              flags,
        input logic [8*DATA_BYTES-1:0] data
    );
        logic [7:0] acc;
        acc = flags;
        for (int k = 0; k < DATA_BYTES; k++) begin
            acc = acc ^ data[8*k +: 8];
        end
        return acc;
    endfunction

    // Checksum of the word currently offered, captured together with it.
    always_comb begin
        csum_d = xor_checksum(res_flags_i, res_data_i);
    end

    // Select the packet byte addressed by idx_q (data bytes go out MSB first).
    always_comb begin
        data_byte_s = 8'h00;
        for (int k = 0; k < DATA_BYTES; k++) begin
            data_byte_s = (idx_q == IDX_W'(k + 2)) ? data_q[8*(DATA_BYTES-1-k) +: 8]
                                                   : data_byte_s;
        end
        byte_d = (idx_q == IDX_SYNC)  ? SYNC_BYTE :
                 (idx_q == IDX_FLAGS) ? flags_q   :
                 (idx_q == IDX_LAST)  ? csum_q    : data_byte_s;
    end

    // Packet FSM: capture, per-byte start/busy handshake, completion pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            idx_q      <= IDX_SYNC;
            data_q     <= '0;
            flags_q    <= 8'h00;
            csum_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            // Both strobes are single-cycle unless a state below raises them.
            tx_start_q <= 1'b0;
            pkt_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (res_valid_i) begin
                        data_q  <= res_data_i;
                        flags_q <= res_flags_i;
                        csum_q  <= csum_d;
                        idx_q   <= IDX_SYNC;
                        ready_q <= 1'b0;
                        state_q <= ST_SEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    // A transmitter still busy for someone else just delays us.
                    if (!tx_busy_i) begin
                        tx_data_q  <= byte_d;
                        tx_start_q <= 1'b1;
                        state_q    <= ST_WAIT_HI;
                    end else begin
                        state_q <= ST_SEND;
                    end
                end
                ST_WAIT_HI: begin
                    if (tx_busy_i) begin
                        state_q <= ST_WAIT_LO;
                    end else begin
                        state_q <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy_i) begin
                        if (idx_q == IDX_LAST) begin
                            pkt_done_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + IDX_ONE;
                            state_q <= ST_SEND;
                        end
                    end else begin
                        state_q <= ST_WAIT_LO;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    idx_q   <= IDX_SYNC;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_ready_o = ready_q;
    assign busy_o      = ~ready_q;
    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = tx_start_q;
    assign pkt_done_o  = pkt_done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: a behavioural UART transmitter model
// (configurable bit length, 10-bit frames), a serial-line decoder, and a
// second framer instance with a one-byte result word.
module tb_uart_tx_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [15:0] res_data = 16'h0000;
    logic [7:0]  res_flags = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        busy;
    logic        pkt_done;
    logic        ext_busy = 1'b0;

    logic        res_valid2 = 1'b0;
    logic        res_ready2;
    logic [7:0]  res_data2 = 8'h00;
    logic [7:0]  res_flags2 = 8'h00;
    logic [7:0]  tx_data2;
    logic        tx_start2;
    logic        tx_busy2;
    logic        busy2;
    logic        pkt_done2;

    int checks = 0;
    int errors = 0;

    int          bit_clks = 2;
    int          cnt = 0;
    int          cnt2 = 0;
    logic [9:0]  sh = 10'h3FF;
    logic        line_s;
    logic        prev_start = 1'b0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    int          done2_cnt = 0;
    logic [7:0]  cap_q[$];
    logic [7:0]  cap2_q[$];
    logic [7:0]  rx_q[$];

    // 125 MHz system clock
    always #4 clk = ~clk;

    uart_tx_framer #(.DATA_BYTES(2), .SYNC_BYTE(8'hA5)) dut (
        .clk_i(clk), .rst_i(rst), .res_valid_i(res_valid), .res_ready_o(res_ready),
        .res_data_i(res_data), .res_flags_i(res_flags), .tx_data_o(tx_data),
        .tx_start_o(tx_start), .tx_busy_i(tx_busy), .busy_o(busy), .pkt_done_o(pkt_done)
    );

    uart_tx_framer #(.DATA_BYTES(1), .SYNC_BYTE(8'hA5)) dut1 (
        .clk_i(clk), .rst_i(rst), .res_valid_i(res_valid2), .res_ready_o(res_ready2),
        .res_data_i(res_data2), .res_flags_i(res_flags2), .tx_data_o(tx_data2),
        .tx_start_o(tx_start2), .tx_busy_i(tx_busy2), .busy_o(busy2), .pkt_done_o(pkt_done2)
    );

    // Transmitter model: start, 8 data bits LSB first, stop; busy for 10 bit times.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 0;
            sh  <= 10'h3FF;
        end else if (cnt == 0) begin
            if (tx_start) begin
                cnt <= 10 * bit_clks;
                sh  <= {1'b1, tx_data, 1'b0};
            end
        end else begin
            cnt <= cnt - 1;
        end
    end

    assign tx_busy = (cnt != 0) | ext_busy;

    always_comb begin
        line_s = 1'b1;
        if (cnt != 0) line_s = sh[(10 * bit_clks - cnt) / bit_clks];
    end

    // Busy-only model for the one-byte instance (20-cycle frames).
    always @(posedge clk or posedge rst) begin
        if (rst) cnt2 <= 0;
        else if (cnt2 == 0) begin
            if (tx_start2) cnt2 <= 20;
        end else cnt2 <= cnt2 - 1;
    end

    assign tx_busy2 = (cnt2 != 0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte monitor: every start pulse is logged and must be 1 cycle, with tx idle.
    always @(posedge clk) begin
        if (tx_start) begin
            start_cnt <= start_cnt + 1;
            cap_q.push_back(tx_data);
            chk("start_while_busy", tx_busy, 1'b0);
            chk("start_width", prev_start, 1'b0);
        end
        if (pkt_done) done_cnt <= done_cnt + 1;
        if (tx_start2) cap2_q.push_back(tx_data2);
        if (pkt_done2) done2_cnt <= done2_cnt + 1;
    end

    // Previous-cycle copy of tx_start for the pulse-width check.
    always @(posedge clk) prev_start <= tx_start;

    // Serial decoder: sample mid-bit, keep bytes with a valid stop bit.
    initial begin : decoder
        logic [7:0] b;
        logic       stop;
        forever begin
            @(negedge line_s);
            repeat (bit_clks / 2) @(posedge clk);
            @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                repeat (bit_clks) @(negedge clk);
                b[j] = line_s;
            end
            repeat (bit_clks) @(negedge clk);
            stop = line_s;
            if (stop) rx_q.push_back(b);
        end
    end

    task automatic offer(input logic [15:0] d, input logic [7:0] f);
        int n;
        @(negedge clk);
        res_valid = 1'b1;
        res_data  = d;
        res_flags = f;
        n = 0;
        while (!res_ready && n < 100000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", res_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (!pkt_done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("pkt_done_seen", pkt_done, 1'b1);
    endtask

    task automatic chk_bytes(input string tag, input int which, input int base,
                             input logic [79:0] exp, input int n);
        int         sz;
        logic [7:0] got;
        sz = (which == 0) ? cap_q.size() : (which == 1) ? rx_q.size() : cap2_q.size();
        chk({tag, "_count"}, 64'(sz - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            got = 8'hxx;
            if (base + i < sz) begin
                got = (which == 0) ? cap_q[base + i] :
                      (which == 1) ? rx_q[base + i]  : cap2_q[base + i];
            end
            chk(tag, got, exp[8*(n-1-i) +: 8]);
        end
    endtask

    initial begin : stimulus
        int base_cap;
        int base_rx;
        int base_start;
        int base_done;
        int cyc;
        int n;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_pkt_done", pkt_done, 1'b0);
        chk("rst_res_ready", res_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- basic packet 1234/01 ----------------
        base_cap = cap_q.size();
        base_rx  = rx_q.size();
        base_start = start_cnt;
        base_done  = done_cnt;
        offer(16'h1234, 8'h01);
        chk("e0_busy", busy, 1'b1);
        chk("e0_ready", res_ready, 1'b0);
        chk("e0_tx_start", tx_start, 1'b0);
        @(negedge clk);
        chk("e1_tx_start", tx_start, 1'b1);
        chk("e1_tx_data", tx_data, 8'hA5);
        @(negedge clk);
        chk("e2_tx_start", tx_start, 1'b0);
        chk("e2_tx_busy", tx_busy, 1'b1);
        chk("e2_tx_data_hold", tx_data, 8'hA5);
        cyc = 2;
        while (!pkt_done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("pkt_latency", 64'(cyc), 64'd115);
        chk("done_ready_low", res_ready, 1'b0);
        chk("done_tx_data_hold", tx_data, 8'h27);
        @(negedge clk);
        chk("post_done_pulse", pkt_done, 1'b0);
        chk("post_done_ready", res_ready, 1'b1);
        chk("post_done_busy", busy, 1'b0);
        chk_bytes("pkt1_bytes", 0, base_cap, 80'hA501123427, 5);
        chk_bytes("pkt1_serial", 1, base_rx, 80'hA501123427, 5);
        chk("pkt1_starts", 64'(start_cnt - base_start), 64'd5);
        chk("pkt1_dones", 64'(done_cnt - base_done), 64'd1);

        // ---------------- transmitter held busy by someone else ----------------
        base_cap = cap_q.size();
        @(negedge clk);
        ext_busy = 1'b1;
        offer(16'hABCD, 8'h10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("hold_no_start", tx_start, 1'b0);
            chk("hold_busy", busy, 1'b1);
        end
        ext_busy = 1'b0;
        @(negedge clk);
        chk("hold_release_start", tx_start, 1'b1);
        chk("hold_release_data", tx_data, 8'hA5);
        wait_done(1000);
        @(negedge clk);
        chk_bytes("hold_bytes", 0, base_cap, 80'hA510ABCD76, 5);

        // ---------------- back-to-back with res_valid held ----------------
        base_cap   = cap_q.size();
        base_start = start_cnt;
        base_done  = done_cnt;
        @(negedge clk);
        res_valid = 1'b1;
        res_data  = 16'hFFFF;
        res_flags = 8'h00;
        @(posedge clk);
        @(negedge clk);
        res_data  = 16'h0000;
        res_flags = 8'h80;
        wait_done(1000);
        chk("b2b_first_starts", 64'(start_cnt - base_start), 64'd5);
        chk("b2b_ready_at_done", res_ready, 1'b0);
        @(negedge clk);
        chk("b2b_ready_after_done", res_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        res_valid = 1'b0;
        chk("b2b_second_taken", res_ready, 1'b0);
        wait_done(1000);
        @(negedge clk);
        chk_bytes("b2b_bytes", 0, base_cap, 80'hA500FFFF00A580000080, 10);
        chk("b2b_dones", 64'(done_cnt - base_done), 64'd2);

        // ---------------- reset during byte index 2 ----------------
        base_start = start_cnt;
        base_done  = done_cnt;
        offer(16'h5566, 8'h77);
        n = 0;
        while (!(tx_start && tx_data == 8'h55) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached", tx_start, 1'b1);
        #1;
        rst       = 1'b1;
        res_valid = 1'b1;
        res_data  = 16'hFFFF;
        res_flags = 8'hFF;
        #1;
        chk("rst_mid_tx_start", tx_start, 1'b0);
        chk("rst_mid_tx_data", tx_data, 8'h00);
        chk("rst_mid_pkt_done", pkt_done, 1'b0);
        chk("rst_mid_ready", res_ready, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        res_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("rst_no_more_starts", 64'(start_cnt - base_start), 64'd2);
        chk("rst_no_done", 64'(done_cnt - base_done), 64'd0);
        chk("rst_nothing_captured", busy, 1'b0);
        base_cap = cap_q.size();
        offer(16'h5566, 8'h77);
        wait_done(1000);
        @(negedge clk);
        chk_bytes("after_rst_bytes", 0, base_cap, 80'hA577556644, 5);

        // ---------------- one-byte result instance ----------------
        @(negedge clk);
        res_valid2 = 1'b1;
        res_data2  = 8'hC3;
        res_flags2 = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        res_valid2 = 1'b0;
        n = 0;
        while (!pkt_done2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("db1_done", pkt_done2, 1'b1);
        @(negedge clk);
        chk_bytes("db1_bytes", 2, 0, 80'hA53CC3FF, 4);
        chk("db1_dones", 64'(done2_cnt), 64'd1);

        // ---------------- full chain at 230400 baud ----------------
        bit_clks = 543;
        base_cap = cap_q.size();
        base_rx  = rx_q.size();
        offer(16'hBEEF, 8'h5A);
        wait_done(40000);
        @(negedge clk);
        chk_bytes("chain_bytes", 0, base_cap, 80'hA55ABEEF0B, 5);
        chk_bytes("chain_serial", 1, base_rx, 80'hA55ABEEF0B, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Packetizer stage directly upstream of the UART transmitter. Accepts one ALU result word plus a status-flag byte over a valid/ready handshake. Serializes the result into a framed byte packet: sync, flags, data bytes MSB-first, XOR checksum. Feeds the transmitter one byte at a time through its `tx_start`/`tx_busy` handshake.

## Interface
- `DATA_BYTES`, 2: result width in bytes; legal range 1..8.
- `SYNC_BYTE`, 8'hA5: first byte of every packet.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `res_valid`  in  1  result word offered.
- `res_ready`  out  1  framer can accept a result; high only in IDLE.
- `res_data`  in  8*DATA_BYTES  result word.
- `res_flags`  in  8  status flags sent as byte 1.
- `tx_data`  out  8  byte presented to the transmitter.
- `tx_start`  out  1  one-cycle request to the transmitter.
- `tx_busy`  in  1  transmitter busy; rises the cycle after an accepted `tx_start` and falls when the stop bit ends.
- `busy`  out  1  packet in progress; equals !`res_ready`.
- `pkt_done`  out  1  one-cycle pulse after the last byte is fully transmitted.

## Operation
- Packet length N = DATA_BYTES+3. Byte order:
  - `SYNC_BYTE`
  - `res_flags`
  - `res_data` bytes from most-significant to least-significant
  - checksum = XOR of `res_flags` and all `res_data` bytes (the sync byte is excluded).
- Accept: on a clk edge with `res_valid` && `res_ready`, register `res_data`, `res_flags` and the checksum. Set byte index to 0 and go to SEND. Inputs are don't-care at all other times.
- FSM states:
  - IDLE: `res_ready`=1. On accept → SEND.
  - SEND: if `tx_busy`=0, register `tx_data`=byte[idx] and `tx_start`=1 → WAIT_HI. If `tx_busy`=1 (transmitter still busy from a foreign user), hold in SEND.
  - WAIT_HI: `tx_start` is back to 0. Wait for `tx_busy`=1 → WAIT_LO.
  - WAIT_LO: wait for `tx_busy`=0. If idx=N-1 → DONE. Else idx+1 → SEND.
  - DONE: `pkt_done`=1 for this single cycle → IDLE.
- `tx_start` is registered and high for exactly one cycle per byte. It is never asserted while `tx_busy`=1.
- `tx_data` holds its value from the `tx_start` cycle until the next byte is loaded.
- Byte index width is clog2(DATA_BYTES+3). The index never wraps within a packet.
- Back-to-back results: `res_ready` goes high again in the cycle after DONE. There is no input buffering.

## Timing
- Reset values: `tx_start`=0, `tx_data`=8'h00, `pkt_done`=0, state=IDLE (so `res_ready`=1, `busy`=0), idx=0, captured registers = 0.
- Reset asserted mid-packet aborts immediately: the remaining bytes are not sent, and no `pkt_done` is produced. A `tx_start` pulse in flight is cleared asynchronously.
- Accept at edge E:
  - SEND is entered at E.
  - `tx_start` is visible after edge E+1 (when `tx_busy`=0).
  - The transmitter raises `tx_busy` after E+2, giving WAIT_LO at E+3.
- Per-byte overhead beyond the transmitter's frame time is 3 cycles: SEND, WAIT_HI, and the WAIT_LO exit.
- `pkt_done` asserts the cycle after `tx_busy` falls for byte N-1. `res_ready` rises one cycle later.
- If `res_valid` and `rst` rise together, reset wins and nothing is captured.

## Test plan
- DATA_BYTES=2, `res_data`=16'h1234, `res_flags`=8'h01, bench transmitter model (`tx_busy` for 20 cycles) → `tx_data` sequence A5,01,12,34,27. Exactly 5 `tx_start` pulses, each one cycle wide. One `pkt_done` pulse.
- Hold `tx_busy`=1 externally when a packet is accepted → framer stays in SEND with `tx_start`=0. The first pulse appears the cycle after `tx_busy` drops.
- Two results (16'hFFFF/8'h00, then 16'h0000/8'h80) offered back-to-back with `res_valid` held high:
  - second is accepted only after the first packet's `pkt_done`;
  - checksums are 00 and 80;
  - there is no byte interleaving.
- Assert `rst` during byte 3 of a packet → outputs return to their reset values immediately. No further `tx_start`, no `pkt_done`. A new result after reset produces a full packet beginning with A5.
- DATA_BYTES=1, `res_data`=8'hC3, `res_flags`=8'h3C → bytes A5,3C,C3,FF.
- Full chain with the real 125 MHz / 230400 transmitter: decode the serial line, and check that the decoded bytes equal the packet.
